// File: rtl/uart_frame_tx_ctrl_pkg.sv
// Shared types and constants for the frame transmit sequencer.
// Holds the FSM state encoding and the fixed preamble/trailer byte values.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOT  = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [7:0] EOT_BYTE  = 8'hAA;

    // Wider of two widths, used to size the shared phase counter.
    function automatic int max_width(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/uart_frame_tx_ctrl_if.sv
// Bus bundle between the frame sequencer and its surroundings:
// frame timer, transmit buffer read port and UART transmitter.
interface uart_frame_tx_ctrl_if #(
    parameter int AW = 15
) ();
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic          missed_o;
    logic [AW-1:0] mem_adr_o;
    logic [7:0]    mem_dat_i;
    logic          tx_empty_i;
    logic          tx_wr_o;
    logic [7:0]    tx_dat_o;

    modport slave (
        input  start_i, abort_i, len_i, mem_dat_i, tx_empty_i,
        output busy_o, done_o, missed_o, mem_adr_o, tx_wr_o, tx_dat_o
    );

    modport master (
        output start_i, abort_i, len_i, mem_dat_i, tx_empty_i,
        input  busy_o, done_o, missed_o, mem_adr_o, tx_wr_o, tx_dat_o
    );
endinterface

// File: rtl/uart_frame_tx_ctrl_pacer.sv
// UART write-strobe pacer: issues a registered strobe plus byte only when the
// transmitter reported empty and no strobe occurred in the two prior cycles.
module uart_tx_pacer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_empty_i,
    output logic       tx_wr_o,
    output logic [7:0] tx_dat_o,
    output logic       ack_o
);

    logic       wr_d;
    logic       wr_q;
    logic       wr_prev_q;
    logic [7:0] dat_d;
    logic [7:0] dat_q;
    logic       ack_s;

    // Two-cycle quiet window covers the UART empty-flag drop and buffer read latency.
    always_comb begin
        ack_s = req_i && tx_empty_i && !wr_q && !wr_prev_q;
        wr_d  = ack_s;
        if (ack_s) begin
            dat_d = byte_i;
        end else begin
            dat_d = dat_q;
        end
    end

    // Strobe history and output byte registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q      <= 1'b0;
            wr_prev_q <= 1'b0;
            dat_q     <= 8'h00;
        end else begin
            wr_q      <= wr_d;
            wr_prev_q <= wr_q;
            dat_q     <= dat_d;
        end
    end

    assign tx_wr_o  = wr_q;
    assign tx_dat_o = dat_q;
    assign ack_o    = ack_s;

endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// Frame transmit sequencer: sync preamble, buffered payload, EOT trailer,
// one frame per accepted start request.
module uart_frame_tx_ctrl
    import uart_frame_pkg::*;
#(
    parameter int AW       = 15,
    parameter int SYNC_LEN = 32,
    parameter int EOT_LEN  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_frame_tx_ctrl_if.slave  bus
);

    localparam int            CW        = max_width(AW, 8);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] EOT_LAST  = CW'(EOT_LEN - 1);
    localparam logic [CW-1:0] EOT_DONE  = CW'(EOT_LEN);
    localparam logic [AW-1:0] ADR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    frame_state_t  state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [AW-1:0] len_d, len_q;
    logic [AW-1:0] adr_d, adr_q;
    logic          first_d, first_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          missed_d, missed_q;
    logic          req_s;
    logic [7:0]    byte_s;
    logic          ack_s;
    logic [AW-1:0] len_last_s;
    logic          tx_wr_s;
    logic [7:0]    tx_dat_s;

    assign len_last_s = len_q - ADR_ONE;

    // Byte request towards the pacer; first_q holds off the cycle right after start.
    always_comb begin
        req_s  = 1'b0;
        byte_s = SYNC_BYTE;
        case (state_q)
            IDLE: begin
                req_s  = 1'b0;
                byte_s = SYNC_BYTE;
            end
            SYNC: begin
                req_s  = !first_q && !bus.abort_i;
                byte_s = SYNC_BYTE;
            end
            DATA: begin
                req_s  = !bus.abort_i;
                byte_s = bus.mem_dat_i;
            end
            EOT: begin
                req_s  = (cnt_q != EOT_DONE) && !bus.abort_i;
                byte_s = EOT_BYTE;
            end
            default: begin
                req_s  = 1'b0;
                byte_s = SYNC_BYTE;
            end
        endcase
    end

    // Sequencer next state; abort overrides everything once a frame is running.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        adr_d    = adr_q;
        first_d  = 1'b0;
        done_d   = 1'b0;
        missed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !done_q) begin
                    state_d = SYNC;
                    len_d   = bus.len_i;
                    cnt_d   = '0;
                    adr_d   = '0;
                    first_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (ack_s && (cnt_q == SYNC_LAST)) begin
                    cnt_d = '0;
                    if (len_q != '0) begin
                        state_d = DATA;
                    end else begin
                        state_d = EOT;
                    end
                end else if (ack_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DATA: begin
                // Address stops at the last payload byte rather than running past it.
                if (ack_s && (cnt_q[AW-1:0] == len_last_s)) begin
                    cnt_d   = '0;
                    state_d = EOT;
                end else if (ack_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    adr_d = adr_q + ADR_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            EOT: begin
                // cnt reaching EOT_DONE marks the cycle after the last trailer strobe.
                if (cnt_q == EOT_DONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (ack_s) begin
                    if (cnt_q == EOT_LAST) begin
                        cnt_d = EOT_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (bus.abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            done_d = done_d;
        end
        if (bus.start_i && (busy_q || done_q)) begin
            missed_d = 1'b1;
        end else begin
            missed_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // Sequencer and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            adr_q    <= '0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            adr_q    <= adr_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    uart_tx_pacer u_pacer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_s),
        .byte_i     (byte_s),
        .tx_empty_i (bus.tx_empty_i),
        .tx_wr_o    (tx_wr_s),
        .tx_dat_o   (tx_dat_s),
        .ack_o      (ack_s)
    );

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.missed_o  = missed_q;
    assign bus.mem_adr_o = adr_q;
    assign bus.tx_wr_o   = tx_wr_s;
    assign bus.tx_dat_o  = tx_dat_s;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Directed bench for uart_frame_tx_ctrl: full frames, empty payload, UART stall,
// missed starts, abort and mid-frame reset, with a registered buffer model.
module tb_uart_frame_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_tx_ctrl_if #(.AW(15)) bus ();

    uart_frame_tx_ctrl #(.AW(15), .SYNC_LEN(32), .EOT_LEN(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [7:0]  mem [0:15];
    logic [7:0]  got [$];
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          have_last = 0;
    int          viol = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          missed_cnt = 0;
    int          max_adr = 0;

    // Synchronous-read buffer: data follows the address by one cycle.
    always @(posedge clk) bus.mem_dat_i <= mem[bus.mem_adr_o[3:0]];

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.tx_wr_o === 1'b1) begin
            got.push_back(bus.tx_dat_o);
            if (have_last != 0 && (cyc - last_wr_cyc) < 3) viol++;
            last_wr_cyc = cyc;
            have_last = 1;
        end
        if (bus.done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.missed_o === 1'b1) missed_cnt++;
        if (bus.busy_o === 1'b1 && int'(bus.mem_adr_o) > max_adr) max_adr = int'(bus.mem_adr_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        got.delete();
        max_adr = 0;
        bus.len_i = 15'(len);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done_o !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk(tag, {31'd0, bus.done_o}, 32'd1);
    endtask

    task automatic wait_strobes(input string tag, input int cnt);
        int n = 0;
        while (got.size() < cnt && n < 1000) begin
            step();
            n++;
        end
        chk(tag, got.size(), cnt);
    endtask

    task automatic chk_stream(input string tag, input int len);
        logic [7:0] e [$];
        for (int i = 0; i < 32; i++) e.push_back(8'hFF);
        for (int i = 0; i < len; i++) e.push_back(mem[i]);
        for (int i = 0; i < 16; i++) e.push_back(8'hAA);
        chk({tag, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, e[i]});
    endtask

    initial begin
        int d0;
        int m0;
        int n0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.len_i = 15'd0;
        bus.tx_empty_i = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        // Reset state
        repeat (3) step();
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_missed", {31'd0, bus.missed_o}, 32'd0);
        chk("rst_tx_wr", {31'd0, bus.tx_wr_o}, 32'd0);
        chk("rst_tx_dat", {24'd0, bus.tx_dat_o}, 32'd0);
        chk("rst_adr", {17'd0, bus.mem_adr_o}, 32'd0);
        rst = 1'b0;
        step();

        // Frame with 4 payload bytes
        d0 = done_cnt; m0 = missed_cnt;
        start_frame(4);
        chk("t1_busy_edge0", {31'd0, bus.busy_o}, 32'd1);
        chk("t1_no_wr_edge0", {31'd0, bus.tx_wr_o}, 32'd0);
        step();
        chk("t1_no_wr_edge1", {31'd0, bus.tx_wr_o}, 32'd0);
        wait_done("t1_done");
        chk("t1_busy_fall", {31'd0, bus.busy_o}, 32'd0);
        step();
        chk("t1_done_width", {31'd0, bus.done_o}, 32'd0);
        chk("t1_done_gap", done_cyc - last_wr_cyc, 32'd1);
        chk_stream("t1", 4);
        chk("t1_done_cnt", done_cnt - d0, 32'd1);
        chk("t1_missed_cnt", missed_cnt - m0, 32'd0);
        chk("t1_max_adr", max_adr, 32'd3);

        // Empty payload
        start_frame(0);
        wait_done("t2_done");
        step();
        chk_stream("t2", 0);
        chk("t2_max_adr", max_adr, 32'd0);

        // UART stall mid-payload
        mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F; mem[3] = 8'hF0;
        start_frame(4);
        wait_strobes("t3_reach", 34);
        bus.tx_empty_i = 1'b0;
        repeat (100) step();
        chk("t3_hold", got.size(), 32'd34);
        bus.tx_empty_i = 1'b1;
        wait_done("t3_done");
        step();
        chk_stream("t3", 4);

        // Start during EOT, then start coincident with done
        d0 = done_cnt; m0 = missed_cnt;
        start_frame(4);
        wait_strobes("t4_reach", 38);
        bus.len_i = 15'd7;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("t4_missed_eot", {31'd0, bus.missed_o}, 32'd1);
        chk("t4_still_busy", {31'd0, bus.busy_o}, 32'd1);
        wait_done("t4_done");
        bus.len_i = 15'd2;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk("t4_missed_done", {31'd0, bus.missed_o}, 32'd1);
        chk("t4_not_started", {31'd0, bus.busy_o}, 32'd0);
        step();
        chk_stream("t4", 4);
        chk("t4_done_cnt", done_cnt - d0, 32'd1);
        chk("t4_missed_cnt", missed_cnt - m0, 32'd2);
        start_frame(2);
        wait_done("t4b_done");
        step();
        chk_stream("t4b", 2);

        // Abort during payload
        d0 = done_cnt;
        start_frame(4);
        wait_strobes("t5_reach", 34);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("t5_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t5_no_wr", {31'd0, bus.tx_wr_o}, 32'd0);
        repeat (40) step();
        chk("t5_strobes", got.size(), 32'd34);
        chk("t5_no_done", done_cnt - d0, 32'd0);
        start_frame(1);
        wait_done("t5b_done");
        step();
        chk_stream("t5b", 1);

        // Reset mid-SYNC
        d0 = done_cnt;
        start_frame(4);
        wait_strobes("t6_reach", 5);
        rst = 1'b1;
        #1;
        chk("t6_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_tx_dat", {24'd0, bus.tx_dat_o}, 32'd0);
        chk("t6_tx_wr", {31'd0, bus.tx_wr_o}, 32'd0);
        chk("t6_adr", {17'd0, bus.mem_adr_o}, 32'd0);
        chk("t6_done", {31'd0, bus.done_o}, 32'd0);
        chk("t6_missed", {31'd0, bus.missed_o}, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        n0 = got.size();
        repeat (30) step();
        chk("t6_no_strobe", got.size() - n0, 32'd0);
        chk("t6_idle", {31'd0, bus.busy_o}, 32'd0);
        chk("t6_no_done", done_cnt - d0, 32'd0);
        chk("spacing_viol", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
